// File: rtl/ocm_cdf_sampler.sv
// ocm_cdf_sampler: maps uniform 32-bit random words to signed table values by binary search of a sorted CDF table.
// Optional feature macro OCM_SAMPLER_STATS_EN adds stat_samples / stat_clip counters.
module ocm_cdf_sampler #(
    parameter int unsigned LOG2_ENTRIES = 8,
    parameter logic [13:0] TABLE_BASE   = 14'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sample,
    output logic [13:0] mem_address,
    output logic        mem_chipselect,
    input  logic [63:0] mem_readdata
`ifdef OCM_SAMPLER_STATS_EN
    ,
    output logic [31:0] stat_samples,
    output logic [15:0] stat_clip
`endif
);

    localparam int unsigned LW = LOG2_ENTRIES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CMP,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_in_ready;
    logic          r_out_valid;
    logic [31:0]   r_out_sample;
    logic          r_cs;
    logic [13:0]   r_mem_address;
    logic [31:0]   r_rand;
    logic [LW-1:0] r_lo;
    logic [LW-1:0] r_hi;
    logic [LW-1:0] r_probe;
    logic          r_final;

    logic [LW-1:0] w_lo_nxt;
    logic [LW-1:0] w_hi_nxt;
    logic [LW:0]   w_sum;
    logic [LW-1:0] w_probe;
    logic          w_final;
    logic          w_accept;
    logic          w_load_sample;
    logic          w_below;

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_sample     = r_out_sample;
    assign mem_address    = r_mem_address;
    assign mem_chipselect = r_cs;

    assign w_below = (r_rand < mem_readdata[63:32]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lo_nxt      = r_lo;
        w_hi_nxt      = r_hi;
        w_accept      = 1'b0;
        w_load_sample = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_lo_nxt    = '0;
                    w_hi_nxt    = '1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_CMP;
            end
            ST_CMP: begin
                if (r_final) begin
                    w_load_sample = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    if (w_below) begin
                        w_hi_nxt = r_probe;
                    end else begin
                        w_lo_nxt = r_probe + LW'(1);
                    end
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Probe index for the upcoming REQ, derived from the interval it will see.
    // The interval halves every step, so a collapsed interval marks the final fetch.
    always_comb begin
        w_sum   = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
        w_final = (w_lo_nxt == w_hi_nxt);
        w_probe = w_final ? w_lo_nxt : w_sum[LW:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sample  <= '0;
            r_cs          <= 1'b0;
            r_mem_address <= TABLE_BASE;
            r_rand        <= '0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_probe       <= '0;
            r_final       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_cs        <= (w_state_nxt == ST_REQ);
            r_lo        <= w_lo_nxt;
            r_hi        <= w_hi_nxt;
            if (w_accept) begin
                r_rand <= in_rand;
            end
            if (w_state_nxt == ST_REQ) begin
                r_probe       <= w_probe;
                r_final       <= w_final;
                r_mem_address <= TABLE_BASE + 14'(w_probe);
            end
            if (w_load_sample) begin
                r_out_sample <= mem_readdata[31:0];
            end
        end
    end

`ifdef OCM_SAMPLER_STATS_EN
    logic        r_hit;
    logic        r_clip;
    logic [31:0] r_stat_samples;
    logic [15:0] r_stat_clip;
    logic        w_handshake;

    assign w_handshake  = (r_state == ST_DONE) && out_ready;
    assign stat_samples = r_stat_samples;
    assign stat_clip    = r_stat_clip;

    // A clip is a result on the last entry reached without any search step hitting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit          <= 1'b0;
            r_clip         <= 1'b0;
            r_stat_samples <= '0;
            r_stat_clip    <= '0;
        end else begin
            if (w_accept) begin
                r_hit <= 1'b0;
            end else if ((r_state == ST_CMP) && !r_final && w_below) begin
                r_hit <= 1'b1;
            end
            if (w_load_sample) begin
                r_clip <= (r_probe == {LW{1'b1}}) && !r_hit;
            end
            if (w_handshake) begin
                r_stat_samples <= r_stat_samples + 32'd1;
                if (r_clip && (r_stat_clip != '1)) begin
                    r_stat_clip <= r_stat_clip + 16'd1;
                end
            end
        end
    end
`endif

endmodule
